// File: rtl/rggen_bit_field_access_initiator.sv
// rtl/rggen_bit_field_access_initiator.sv - host request to single-cycle bit field access bridge
// Optional write readback/compare enabled by RGGEN_BIT_FIELD_ACCESS_INITIATOR_READBACK_EN.
module rggen_bit_field_access_initiator #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_request_valid,
  output logic             o_request_ready,
  input  logic             i_request_write,
  input  logic [WIDTH-1:0] i_request_data,
  input  logic [WIDTH-1:0] i_request_mask,
  output logic             o_response_valid,
  input  logic             i_response_ready,
  output logic [WIDTH-1:0] o_response_data,
  output logic             o_response_error,
  output logic             o_bit_field_valid,
  output logic [WIDTH-1:0] o_bit_field_read_mask,
  output logic [WIDTH-1:0] o_bit_field_write_mask,
  output logic [WIDTH-1:0] o_bit_field_write_data,
  input  logic [WIDTH-1:0] i_bit_field_read_data
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    READBACK,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_valid_q, resp_valid_d;
  logic             bf_valid_q, bf_valid_d;
  logic [WIDTH-1:0] bf_rmask_q, bf_rmask_d;
  logic [WIDTH-1:0] bf_wmask_q, bf_wmask_d;
  logic [WIDTH-1:0] bf_wdata_q, bf_wdata_d;
`ifdef RGGEN_BIT_FIELD_ACCESS_INITIATOR_READBACK_EN
  logic [WIDTH-1:0] data_q, data_d;
  logic             resp_err_q, resp_err_d;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bit field strobes are computed from the next state so they are flop outputs
  // aligned with the access state itself.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    resp_data_d  = resp_data_q;
    bf_valid_d   = 1'b0;
    bf_rmask_d   = '0;
    bf_wmask_d   = '0;
    bf_wdata_d   = '0;
`ifdef RGGEN_BIT_FIELD_ACCESS_INITIATOR_READBACK_EN
    data_d       = data_q;
    resp_err_d   = resp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_request_valid) begin
          mask_d      = i_request_mask;
          resp_data_d = '0;
`ifdef RGGEN_BIT_FIELD_ACCESS_INITIATOR_READBACK_EN
          data_d      = i_request_data;
          resp_err_d  = 1'b0;
`endif
          if (i_request_mask == '0) begin
            state_d = RESP;
          end else if (i_request_write) begin
            state_d    = WRITE;
            bf_valid_d = 1'b1;
            bf_wmask_d = i_request_mask;
            bf_wdata_d = i_request_data & i_request_mask;
          end else begin
            state_d    = READ;
            bf_valid_d = 1'b1;
            bf_rmask_d = i_request_mask;
          end
        end
      end
      READ: begin
        resp_data_d = i_bit_field_read_data & mask_q;
        state_d     = RESP;
      end
      WRITE: begin
        resp_data_d = '0;
`ifdef RGGEN_BIT_FIELD_ACCESS_INITIATOR_READBACK_EN
        state_d    = READBACK;
        bf_valid_d = 1'b1;
        bf_rmask_d = mask_q;
`else
        state_d    = RESP;
`endif
      end
`ifdef RGGEN_BIT_FIELD_ACCESS_INITIATOR_READBACK_EN
      READBACK: begin
        resp_data_d = i_bit_field_read_data & mask_q;
        resp_err_d  = (i_bit_field_read_data & mask_q) != (data_q & mask_q);
        state_d     = RESP;
      end
`endif
      RESP: begin
        if (i_response_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mask_q       <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      bf_valid_q   <= 1'b0;
      bf_rmask_q   <= '0;
      bf_wmask_q   <= '0;
      bf_wdata_q   <= '0;
`ifdef RGGEN_BIT_FIELD_ACCESS_INITIATOR_READBACK_EN
      data_q       <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      mask_q       <= mask_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      bf_valid_q   <= bf_valid_d;
      bf_rmask_q   <= bf_rmask_d;
      bf_wmask_q   <= bf_wmask_d;
      bf_wdata_q   <= bf_wdata_d;
`ifdef RGGEN_BIT_FIELD_ACCESS_INITIATOR_READBACK_EN
      data_q       <= data_d;
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  // Ready is gated by reset directly so it is low for the whole reset window.
  assign o_request_ready        = (state_q == IDLE) && !i_rst;
  assign o_response_valid       = resp_valid_q;
  assign o_response_data        = resp_data_q;
  assign o_bit_field_valid      = bf_valid_q;
  assign o_bit_field_read_mask  = bf_rmask_q;
  assign o_bit_field_write_mask = bf_wmask_q;
  assign o_bit_field_write_data = bf_wdata_q;
`ifdef RGGEN_BIT_FIELD_ACCESS_INITIATOR_READBACK_EN
  assign o_response_error = resp_err_q;
`else
  assign o_response_error = 1'b0;
`endif

endmodule

// File: tb/tb_rggen_bit_field_access_initiator.sv
// tb/tb_rggen_bit_field_access_initiator.sv - scoreboard bench for rggen_bit_field_access_initiator
// Expectations follow RGGEN_BIT_FIELD_ACCESS_INITIATOR_READBACK_EN when defined.
module tb_rggen_bit_field_access_initiator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [7:0] req_data = '0;
  logic [7:0] req_mask = '0;
  logic       resp_valid;
  logic       resp_ready = 1'b1;
  logic [7:0] resp_data;
  logic       resp_error;
  logic       bf_valid;
  logic [7:0] bf_rmask;
  logic [7:0] bf_wmask;
  logic [7:0] bf_wdata;
  logic [7:0] bf_rd = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = -1;
  bit prev_valid = 1'b0;

  typedef struct {
    logic [7:0] rm;
    logic [7:0] wm;
    logic [7:0] wd;
    int         c;
  } bf_t;

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         c;
  } resp_t;

  bf_t   bf_q[$];
  resp_t resp_q[$];

  rggen_bit_field_access_initiator #(.WIDTH(8)) dut (
    .i_clk                  (clk),
    .i_rst                  (rst),
    .i_request_valid        (req_valid),
    .o_request_ready        (req_ready),
    .i_request_write        (req_write),
    .i_request_data         (req_data),
    .i_request_mask         (req_mask),
    .o_response_valid       (resp_valid),
    .i_response_ready       (resp_ready),
    .o_response_data        (resp_data),
    .o_response_error       (resp_error),
    .o_bit_field_valid      (bf_valid),
    .o_bit_field_read_mask  (bf_rmask),
    .o_bit_field_write_mask (bf_wmask),
    .o_bit_field_write_data (bf_wdata),
    .i_bit_field_read_data  (bf_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected bit field accesses and responses as the DUT presents them.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bf_valid) begin
        if (bf_q.size() == 0) begin
          chk("bf_unexpected_pulse", 1, 0);
        end else begin
          bf_t e;
          e = bf_q.pop_front();
          chk("bf_cycle", cyc, e.c);
          chk("bf_read_mask", bf_rmask, e.rm);
          chk("bf_write_mask", bf_wmask, e.wm);
          chk("bf_write_data", bf_wdata, e.wd);
        end
      end
      if (resp_valid) begin
        chk("ready_low_in_resp", req_ready, 0);
        if (resp_q.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          if (!prev_valid) chk("resp_cycle", cyc, resp_q[0].c);
          chk("resp_data", resp_data, resp_q[0].d);
          chk("resp_error", resp_error, resp_q[0].e);
          if (resp_ready) begin
            acc_cyc = cyc;
            void'(resp_q.pop_front());
          end
        end
      end
      prev_valid = resp_valid;
    end
  end

  // Called #1 after a posedge; returns the handshake cycle in n.
  task automatic issue(input bit w, input logic [7:0] d, input logic [7:0] m,
                       input logic [7:0] exp_d, input bit exp_e, input bit keep,
                       output int n);
    bit rb;
    bf_t b;
    resp_t r;
`ifdef RGGEN_BIT_FIELD_ACCESS_INITIATOR_READBACK_EN
    rb = 1'b1;
`else
    rb = 1'b0;
`endif
    req_write = w;
    req_data  = d;
    req_mask  = m;
    req_valid = 1'b1;
    n = -1;
    for (int k = 0; k < 50 && n < 0; k++) begin
      @(negedge clk);
      if (req_ready) n = cyc;
    end
    chk("req_handshake_timeout", n >= 0, 1);
    if (n >= 0) begin
      if (m != 8'h00) begin
        b.rm = w ? 8'h00 : m;
        b.wm = w ? m : 8'h00;
        b.wd = w ? (d & m) : 8'h00;
        b.c  = n + 1;
        bf_q.push_back(b);
        if (w && rb) begin
          b.rm = m; b.wm = 8'h00; b.wd = 8'h00; b.c = n + 2;
          bf_q.push_back(b);
        end
      end
      r.d = exp_d;
      r.e = exp_e;
      r.c = (m == 8'h00) ? n + 1 : ((w && rb) ? n + 3 : n + 2);
      resp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(posedge clk);
      #1;
      if (req_ready && resp_q.size() == 0) ok = 1'b1;
    end
    chk("idle_timeout", ok, 1);
  endtask

  initial begin
    int n, n2;
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_error", resp_error, 0);
    chk("rst_bf_valid", bf_valid, 0);
    chk("rst_bf_masks", {bf_rmask, bf_wmask, bf_wdata}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);
    @(posedge clk);
    #1;

    // Full-mask read
    bf_rd = 8'hA5;
    issue(1'b0, 8'h00, 8'hFF, 8'hA5, 1'b0, 1'b0, n);
    wait_idle();

    // Partial write; readback sees matching field value when enabled
    bf_rd = 8'h0C;
`ifdef RGGEN_BIT_FIELD_ACCESS_INITIATOR_READBACK_EN
    issue(1'b1, 8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0, n);
`else
    issue(1'b1, 8'h3C, 8'h0F, 8'h00, 1'b0, 1'b0, n);
`endif
    wait_idle();

    // Partial read masks out unselected bits
    bf_rd = 8'h5A;
    issue(1'b0, 8'hFF, 8'hF0, 8'h50, 1'b0, 1'b0, n);
    wait_idle();

    // Zero-mask write with request valid held for a following read
    bf_rd = 8'h81;
    issue(1'b1, 8'hAA, 8'h00, 8'h00, 1'b0, 1'b1, n);
    issue(1'b0, 8'h00, 8'h81, 8'h81, 1'b0, 1'b0, n2);
    chk("zero_mask_accept_cycle", acc_cyc, n + 1);
    chk("ready_after_accept", n2, acc_cyc + 1);
    wait_idle();

    // Backpressure on a read response
    resp_ready = 1'b0;
    bf_rd = 8'h3C;
    issue(1'b0, 8'h00, 8'h3F, 8'h3C, 1'b0, 1'b0, n);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("bp_resp_seen", seen, 1);
    bf_rd = 8'hC3;
    repeat (5) @(negedge clk);
    chk("bp_valid_held", resp_valid, 1);
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_ready", req_ready, 1);
    chk("bp_valid_drop", resp_valid, 0);

    // Reset while holding a response
    resp_ready = 1'b0;
    bf_rd = 8'h11;
    issue(1'b0, 8'h00, 8'hFF, 8'h11, 1'b0, 1'b0, n);
    @(posedge clk);
    #1;
    chk("pre_rst_resp_valid", resp_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    resp_q.delete();
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_bf_valid", bf_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    @(posedge clk);
    #1;

    // Full write where hardware has cleared bit 0, then a clean one
    bf_rd = 8'hFE;
`ifdef RGGEN_BIT_FIELD_ACCESS_INITIATOR_READBACK_EN
    issue(1'b1, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0, n);
`else
    issue(1'b1, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, n);
`endif
    wait_idle();
    bf_rd = 8'hFF;
`ifdef RGGEN_BIT_FIELD_ACCESS_INITIATOR_READBACK_EN
    issue(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, n);
`else
    issue(1'b1, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, n);
`endif
    wait_idle();

    repeat (5) @(posedge clk);
    #1;
    chk("bf_queue_drained", bf_q.size(), 0);
    chk("resp_queue_drained", resp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
